// File: rtl/hit_pulse_monitor.sv
// hit_pulse_monitor: receive-side checker for the test-pulse path.
// Measures width/period on one selected hit line, counts hits and triggers, flags mismatches.
//
// state | meaning
// IDLE  | waiting for the first leading edge on the selected channel
// HIGH  | selected pulse active; width and period counters running
// LOW   | between pulses; period counter running until the next leading edge
module hit_pulse_monitor #(
  parameter int NCH  = 24,
  parameter int MW   = 12,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  hit_in,
  input  logic            trigger_in,
  input  logic            inv,
  input  logic            enable,
  input  logic            clear,
  input  logic [4:0]      ch_sel,
  input  logic [MW-1:0]   expect_width,
  input  logic [MW-1:0]   expect_interval,
  input  logic [MW-1:0]   expect_ratio,
  output logic [MW-1:0]   meas_width,
  output logic [MW-1:0]   meas_interval,
  output logic            width_valid,
  output logic            interval_valid,
  output logic [CNTW-1:0] hit_count,
  output logic [CNTW-1:0] trig_count,
  output logic            width_err,
  output logic            interval_err,
  output logic            ratio_err,
  output logic [15:0]     err_count,
  output logic [NCH-1:0]  active_mask
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  localparam logic [MW-1:0]   M_ONE = MW'(1);
  localparam logic [MW-1:0]   M_MAX = {MW{1'b1}};
  localparam logic [CNTW-1:0] C_ONE = CNTW'(1);
  localparam logic [5:0]      NCH_W = 6'(NCH);

  state_t         state;
  logic [NCH-1:0] act, act_d;
  logic           trig_act, trig_act_d;
  logic [4:0]     ch_sel_q;
  logic [MW-1:0]  wcnt, pcnt, hits_since;
  logic           first_trig_pending;

  // Input stage is not touched by clear so that clear never fabricates an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      act        <= '0;
      act_d      <= '0;
      trig_act   <= 1'b0;
      trig_act_d <= 1'b0;
      ch_sel_q   <= '0;
    end else begin
      act        <= hit_in ^ {NCH{inv}};
      act_d      <= act;
      trig_act   <= trigger_in ^ inv;
      trig_act_d <= trig_act;
      ch_sel_q   <= ch_sel;
    end
  end

  logic [NCH-1:0] lead;
  logic           sel_valid, sel_change, sel_act, sel_act_d, sel_lead, sel_trail;
  logic           trig_lead, ev_ok, hit_ev, trig_ev;
  logic           w_mis, i_mis, r_mis;
  logic [MW-1:0]  wcnt_inc, pcnt_inc, i_val, hits_next;
  logic [1:0]     err_inc;
  logic [16:0]    err_sum;
  logic [15:0]    err_next;

  always_comb begin
    lead       = act & ~act_d;
    sel_valid  = {1'b0, ch_sel_q} < NCH_W;
    sel_change = ch_sel != ch_sel_q;
    sel_act    = 1'b0;
    sel_act_d  = 1'b0;
    if (sel_valid) begin
      sel_act   = act[ch_sel_q];
      sel_act_d = act_d[ch_sel_q];
    end
    sel_lead  = sel_act & ~sel_act_d;
    sel_trail = ~sel_act & sel_act_d;
    trig_lead = trig_act & ~trig_act_d;

    ev_ok   = enable & ~sel_change;
    hit_ev  = ev_ok & sel_lead & (state != S_HIGH);
    trig_ev = enable & trig_lead;

    wcnt_inc = (wcnt == M_MAX) ? M_MAX : wcnt + M_ONE;
    pcnt_inc = (pcnt == M_MAX) ? M_MAX : pcnt + M_ONE;
    i_val    = (pcnt == M_MAX) ? M_MAX : pcnt - M_ONE;

    // A saturated counter always reports a mismatch, even against an all-ones expectation.
    w_mis = ev_ok & (state == S_HIGH) & sel_trail &
            ((wcnt == M_MAX) | (wcnt != expect_width));
    i_mis = ev_ok & (state == S_LOW) & sel_lead &
            ((pcnt == M_MAX) | (i_val != expect_interval));

    hits_next = (hits_since == M_MAX) ? M_MAX
              : hits_since + {{(MW-1){1'b0}}, hit_ev};
    r_mis = trig_ev & ~first_trig_pending & (expect_ratio != '0) &
            (hits_next != expect_ratio);

    err_inc  = {1'b0, w_mis} + {1'b0, i_mis} + {1'b0, r_mis};
    err_sum  = {1'b0, err_count} + {15'b0, err_inc};
    err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state              <= S_IDLE;
      wcnt               <= '0;
      pcnt               <= '0;
      hits_since         <= '0;
      first_trig_pending <= 1'b1;
      meas_width         <= '0;
      meas_interval      <= '0;
      width_valid        <= 1'b0;
      interval_valid     <= 1'b0;
      hit_count          <= '0;
      trig_count         <= '0;
      width_err          <= 1'b0;
      interval_err       <= 1'b0;
      ratio_err          <= 1'b0;
      err_count          <= '0;
      active_mask        <= '0;
    end else if (!enable) begin
      state          <= S_IDLE;
      width_valid    <= 1'b0;
      interval_valid <= 1'b0;
    end else begin
      width_valid    <= 1'b0;
      interval_valid <= 1'b0;
      active_mask    <= active_mask | lead;
      err_count      <= err_next;
      if (w_mis) width_err    <= 1'b1;
      if (i_mis) interval_err <= 1'b1;
      if (r_mis) ratio_err    <= 1'b1;
      if (hit_ev) hit_count <= hit_count + C_ONE;

      if (trig_ev) begin
        trig_count         <= trig_count + C_ONE;
        hits_since         <= '0;
        first_trig_pending <= 1'b0;
      end else begin
        hits_since <= hits_next;
      end

      if (sel_change) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (sel_lead) begin
              state <= S_HIGH;
              wcnt  <= M_ONE;
              pcnt  <= M_ONE;
            end
          end
          S_HIGH: begin
            pcnt <= pcnt_inc;
            if (sel_trail) begin
              state       <= S_LOW;
              meas_width  <= wcnt;
              width_valid <= 1'b1;
            end else if (sel_act) begin
              wcnt <= wcnt_inc;
            end
          end
          S_LOW: begin
            if (sel_lead) begin
              state          <= S_HIGH;
              meas_interval  <= i_val;
              interval_valid <= 1'b1;
              wcnt           <= M_ONE;
              pcnt           <= M_ONE;
            end else begin
              pcnt <= pcnt_inc;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hit_pulse_monitor.sv
// Bench for hit_pulse_monitor: pulse-train stimulus, event-level reference model,
// expected measurements queued at stimulus time and popped when the DUT reports them.
module tb_hit_pulse_monitor;
  localparam int NCH  = 24;
  localparam int MW   = 12;
  localparam int CNTW = 32;
  localparam int SAT  = 4095;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH-1:0]  hit_in;
  logic            trigger_in, inv, enable, clear;
  logic [4:0]      ch_sel;
  logic [MW-1:0]   expect_width, expect_interval, expect_ratio;
  logic [MW-1:0]   meas_width, meas_interval;
  logic            width_valid, interval_valid;
  logic [CNTW-1:0] hit_count, trig_count;
  logic            width_err, interval_err, ratio_err;
  logic [15:0]     err_count;
  logic [NCH-1:0]  active_mask;

  always #5 clk = ~clk;

  hit_pulse_monitor #(.NCH(NCH), .MW(MW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .hit_in(hit_in), .trigger_in(trigger_in), .inv(inv),
    .enable(enable), .clear(clear), .ch_sel(ch_sel), .expect_width(expect_width),
    .expect_interval(expect_interval), .expect_ratio(expect_ratio),
    .meas_width(meas_width), .meas_interval(meas_interval), .width_valid(width_valid),
    .interval_valid(interval_valid), .hit_count(hit_count), .trig_count(trig_count),
    .width_err(width_err), .interval_err(interval_err), .ratio_err(ratio_err),
    .err_count(err_count), .active_mask(active_mask)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Logical line levels driven this tick and the two previous ticks.
  logic [NCH-1:0] drv, drv_q1, drv_q2;
  logic           trg, trg_q1, trg_q2;
  logic [4:0]     m_sel_prev;
  int             cyc;

  // Reference model state.
  int unsigned    m_hit, m_trig;
  int             m_err, m_hits, m_lead_cyc;
  bit             m_werr, m_ierr, m_rerr, m_first, m_have_prev, m_track;
  logic [NCH-1:0] m_mask;
  int             q_w[$];
  int             q_i[$];

  task automatic model_clear();
    m_hit = 0; m_trig = 0; m_err = 0; m_hits = 0;
    m_werr = 0; m_ierr = 0; m_rerr = 0; m_first = 1;
    m_have_prev = 0; m_track = 0; m_mask = '0;
  endtask

  // Events seen by the monitor on the edge following this tick: the line stage adds one
  // cycle, so edges come from the two previous ticks while controls come from this one.
  task automatic model_step();
    logic [NCH-1:0] ld, tr;
    logic tl;
    int diff, v, nerr, sel;
    bit hit;
    ld = drv_q1 & ~drv_q2;
    tr = ~drv_q1 & drv_q2;
    tl = trg_q1 & ~trg_q2;
    nerr = 0;
    hit = 0;
    if (clear) begin
      model_clear();
      return;
    end
    if (!enable) begin
      m_have_prev = 0;
      m_track = 0;
      return;
    end
    m_mask |= ld;
    sel = int'(m_sel_prev);
    if (ch_sel != m_sel_prev) begin
      m_have_prev = 0;
      m_track = 0;
    end else if (sel < NCH) begin
      if (m_track && tr[sel]) begin
        diff = cyc - m_lead_cyc;
        v = (diff >= SAT) ? SAT : diff;
        q_w.push_back(v);
        if (diff >= SAT || v != int'(expect_width)) begin m_werr = 1; nerr++; end
        m_track = 0;
      end
      if (ld[sel]) begin
        if (m_have_prev) begin
          diff = cyc - m_lead_cyc;
          v = (diff >= SAT) ? SAT : diff - 1;
          q_i.push_back(v);
          if (diff >= SAT || v != int'(expect_interval)) begin m_ierr = 1; nerr++; end
        end
        m_have_prev = 1;
        m_track = 1;
        m_lead_cyc = cyc;
        hit = 1;
        m_hit++;
      end
    end
    if (hit && m_hits < SAT) m_hits++;
    if (tl) begin
      m_trig++;
      if (!m_first && expect_ratio != 0 && m_hits != int'(expect_ratio)) begin
        m_rerr = 1; nerr++;
      end
      m_hits = 0;
      m_first = 0;
    end
    m_err = (m_err + nerr > 65535) ? 65535 : m_err + nerr;
  endtask

  task automatic tick();
    hit_in = drv ^ {NCH{inv}};
    trigger_in = trg ^ inv;
    model_step();
    drv_q2 = drv_q1; drv_q1 = drv;
    trg_q2 = trg_q1; trg_q1 = trg;
    m_sel_prev = ch_sel;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    drv = '0; trg = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(int ch, int w, int g, bit t, logic [NCH-1:0] bg);
    for (int i = 0; i < w; i++) begin
      drv = bg;
      if (ch < NCH) drv[ch] = 1'b1;
      trg = t && (i == 0);
      tick();
    end
    idle(g);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic check_state(string tag);
    check({tag, " hit_count"}, hit_count, m_hit);
    check({tag, " trig_count"}, trig_count, m_trig);
    check({tag, " width_err"}, 32'(width_err), 32'(m_werr));
    check({tag, " interval_err"}, 32'(interval_err), 32'(m_ierr));
    check({tag, " ratio_err"}, 32'(ratio_err), 32'(m_rerr));
    check({tag, " err_count"}, 32'(err_count), m_err);
    check({tag, " active_mask"}, 32'(active_mask), 32'(m_mask));
    check({tag, " widths pending"}, q_w.size(), 0);
    check({tag, " intervals pending"}, q_i.size(), 0);
  endtask

  // Scoreboard side: compare every reported measurement with the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (width_valid) begin
        if (q_w.size() == 0) check("unexpected width_valid", 32'(width_valid), 0);
        else check("meas_width", 32'(meas_width), q_w.pop_front());
      end
      if (interval_valid) begin
        if (q_i.size() == 0) check("unexpected interval_valid", 32'(interval_valid), 0);
        else check("meas_interval", 32'(meas_interval), q_i.pop_front());
      end
    end
  end

  task automatic basic_train(int n);
    for (int p = 0; p < n; p++) pulse(3, 4, 6, 1'b0, '0);
    idle(5);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; enable = 1'b1; inv = 1'b0; ch_sel = 5'd0;
    expect_width = 12'd4; expect_interval = 12'd9; expect_ratio = 12'd0;
    drv = '0; trg = 1'b0; drv_q1 = '0; drv_q2 = '0; trg_q1 = 1'b0; trg_q2 = 1'b0;
    m_sel_prev = 5'd0; cyc = 0; m_lead_cyc = 0;
    hit_in = '0; trigger_in = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset meas_width", 32'(meas_width), 0);
    check("reset meas_interval", 32'(meas_interval), 0);
    check("reset valids", {30'b0, width_valid, interval_valid}, 0);
    check("reset err flags", {29'b0, width_err, interval_err, ratio_err}, 0);
    check_state("reset");

    // Nominal train on channel 3, non-inverted then inverted lines.
    ch_sel = 5'd3;
    idle(3);
    do_clear();
    basic_train(5);
    check_state("nominal");
    check("nominal hit_count lit", hit_count, 5);
    check("nominal err_count lit", 32'(err_count), 0);

    inv = 1'b1;
    do_clear();
    idle(2);
    basic_train(5);
    check_state("inverted");
    check("inverted hit_count lit", hit_count, 5);
    inv = 1'b0;

    // Triggers coincident with every third hit.
    for (int k = 0; k < 2; k++) begin
      expect_ratio = (k == 0) ? 12'd3 : 12'd4;
      do_clear();
      for (int p = 0; p < 9; p++) pulse(3, 4, 6, (p % 3) == 0, '0);
      idle(5);
      check_state(k == 0 ? "ratio3" : "ratio4");
      check("ratio trig_count lit", trig_count, 3);
      check("ratio err_count lit", 32'(err_count), (k == 0) ? 0 : 2);
    end
    expect_ratio = 12'd0;

    // One wide pulse in a width-4 train, period kept at 10.
    do_clear();
    for (int p = 0; p < 5; p++) pulse(3, (p == 2) ? 5 : 4, (p == 2) ? 5 : 6, 1'b0, '0);
    idle(5);
    check_state("wide");
    check("wide err_count lit", 32'(err_count), 1);

    // Line stuck active: width saturates.
    do_clear();
    pulse(3, 5000, 10, 1'b0, '0);
    idle(3);
    check_state("stuck");
    check("stuck meas_width lit", 32'(meas_width), SAT);

    // Channel switch mid-pulse, then clear coincident with a lead.
    do_clear();
    drv = '0; drv[3] = 1'b1; trg = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) ch_sel = 5'd7;
      tick();
    end
    idle(4);
    pulse(7, 3, 5, 1'b1, '0);
    pulse(7, 3, 5, 1'b0, '0);
    idle(3);
    check_state("switch");
    drv = '0; drv[7] = 1'b1;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick(); tick();
    idle(5);
    check_state("clear");
    check("clear hit_count lit", hit_count, 0);
    check("clear active_mask lit", 32'(active_mask), 0);

    // Randomized trains with background channels, channel hops and enable gaps.
    for (int r = 0; r < 8; r++) begin
      int w, g;
      bit t;
      logic [NCH-1:0] bg;
      inv = 1'($urandom_range(0, 1));
      ch_sel = (r == 5) ? 5'd27 : 5'($urandom_range(0, 23));
      expect_width = 12'($urandom_range(1, 5));
      expect_interval = 12'($urandom_range(4, 12));
      expect_ratio = 12'($urandom_range(0, 3));
      do_clear();
      idle(2);
      for (int p = 0; p < 20; p++) begin
        w = $urandom_range(1, 5);
        g = $urandom_range(1, 7);
        t = ($urandom_range(0, 2) == 0);
        bg = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
        if ($urandom_range(0, 14) == 0) ch_sel = 5'($urandom_range(0, 25));
        if ($urandom_range(0, 14) == 0) begin
          enable = 1'b0;
          idle(3);
          enable = 1'b1;
        end
        pulse(int'(ch_sel), w, g, t, bg);
      end
      idle(5);
      check_state("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
